// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps one instruction-memory read in flight and handles decode stalls and branch redirects.
module if_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_stall,
    input  logic                  br_taken,
    input  logic [DATA_WIDTH-1:0] br_target,
    output logic                  im_req_valid,
    input  logic                  im_req_ready,
    output logic [DATA_WIDTH-1:0] im_addr,
    input  logic                  im_rsp_valid,
    input  logic [DATA_WIDTH-1:0] im_rsp_data,
    output logic                  id_valid,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_instr
);

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = {{(DATA_WIDTH-7){1'b0}}, 7'h13};
    localparam logic [DATA_WIDTH-1:0] PC_STEP   = {{(DATA_WIDTH-3){1'b0}}, 3'd4};

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DROP
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] pc_reg, pc_next;
    logic [DATA_WIDTH-1:0] req_pc_reg, req_pc_next;
    logic                  hold_valid_reg, hold_valid_next;
    logic [DATA_WIDTH-1:0] hold_pc_reg, hold_pc_next;
    logic [DATA_WIDTH-1:0] hold_instr_reg, hold_instr_next;
    logic                  id_valid_reg, id_valid_next;
    logic [DATA_WIDTH-1:0] id_pc_reg, id_pc_next;
    logic [DATA_WIDTH-1:0] id_instr_reg, id_instr_next;

    logic                  handshake;
    logic [DATA_WIDTH-1:0] br_target_aligned;
    logic                  br_lsb_unused;

    // The request line must never be seen high while reset is held.
    assign im_req_valid      = (state_reg == ST_REQ) && !rst;
    assign im_addr           = pc_reg;
    assign handshake         = im_req_valid && im_req_ready;
    assign br_target_aligned = {br_target[DATA_WIDTH-1:2], 2'b00};
    assign br_lsb_unused     = ^br_target[1:0];

    assign id_valid = id_valid_reg;
    assign id_pc    = id_pc_reg;
    assign id_instr = id_instr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_REQ;
            pc_reg         <= RESET_PC;
            req_pc_reg     <= RESET_PC;
            hold_valid_reg <= 1'b0;
            hold_pc_reg    <= '0;
            hold_instr_reg <= NOP_INSTR;
            id_valid_reg   <= 1'b0;
            id_pc_reg      <= '0;
            id_instr_reg   <= NOP_INSTR;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            req_pc_reg     <= req_pc_next;
            hold_valid_reg <= hold_valid_next;
            hold_pc_reg    <= hold_pc_next;
            hold_instr_reg <= hold_instr_next;
            id_valid_reg   <= id_valid_next;
            id_pc_reg      <= id_pc_next;
            id_instr_reg   <= id_instr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        req_pc_next     = req_pc_reg;
        hold_valid_next = hold_valid_reg;
        hold_pc_next    = hold_pc_reg;
        hold_instr_next = hold_instr_reg;
        id_valid_next   = id_valid_reg;
        id_pc_next      = id_pc_reg;
        id_instr_next   = id_instr_reg;

        if (br_taken) begin
            // Redirect wins over stall; any in-flight read becomes stale.
            pc_next         = br_target_aligned;
            id_valid_next   = 1'b0;
            hold_valid_next = 1'b0;
            unique case (state_reg)
                ST_REQ:  state_next = handshake ? ST_DROP : ST_REQ;
                ST_WAIT: state_next = im_rsp_valid ? ST_REQ : ST_DROP;
                ST_HOLD: state_next = ST_REQ;
                ST_DROP: state_next = im_rsp_valid ? ST_REQ : ST_DROP;
                default: state_next = ST_REQ;
            endcase
        end else begin
            // Decode consumes the current entry unless stalled; refilled below if a word arrives.
            if (!id_stall) begin
                id_valid_next = 1'b0;
            end
            unique case (state_reg)
                ST_REQ: begin
                    if (handshake) begin
                        req_pc_next = pc_reg;
                        pc_next     = pc_reg + PC_STEP;
                        state_next  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (im_rsp_valid) begin
                        if (!id_stall) begin
                            id_valid_next = 1'b1;
                            id_pc_next    = req_pc_reg;
                            id_instr_next = im_rsp_data;
                            state_next    = ST_REQ;
                        end else begin
                            hold_valid_next = 1'b1;
                            hold_pc_next    = req_pc_reg;
                            hold_instr_next = im_rsp_data;
                            state_next      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!id_stall) begin
                        id_valid_next   = hold_valid_reg;
                        id_pc_next      = hold_pc_reg;
                        id_instr_next   = hold_instr_reg;
                        hold_valid_next = 1'b0;
                        state_next      = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (im_rsp_valid) begin
                        state_next = ST_REQ;
                    end
                end
                default: state_next = ST_REQ;
            endcase
        end
    end

endmodule
